// File: rtl/fp_sgnj_pkg.sv
// fp_sgnj_pkg: shared types for the FP sign-injection dispatch slice.
// funct3 codes, FSM states, the queued op bundle and the unit decoder.
package fp_sgnj_pkg;

    localparam logic [2:0] F3_SGNJ  = 3'b000;
    localparam logic [2:0] F3_SGNJN = 3'b001;
    localparam logic [2:0] F3_SGNJX = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WB
    } state_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } op_t;

    // one-hot {sgnjx, sgnjn, sgnj}; all zero marks an illegal funct3
    typedef logic [2:0] sel_t;

    function automatic sel_t f3_decode(input logic [2:0] f3);
        sel_t s;
        s = '0;
        case (f3)
            F3_SGNJ:  s = 3'b001;
            F3_SGNJN: s = 3'b010;
            F3_SGNJX: s = 3'b100;
            default:  s = 3'b000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fp_sgnj_if.sv
// fp_sgnj_if: op issue handshake and register-file writeback handshake.
// master drives ops and accepts results; slave is the dispatch stage.
interface fp_sgnj_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_illegal;

    modport master (
        output in_valid,
        output in_funct3,
        output in_rd,
        output in_rs1,
        output in_rs2,
        output wb_ready,
        input  in_ready,
        input  wb_valid,
        input  wb_rd,
        input  wb_data,
        input  wb_illegal
    );

    modport slave (
        input  in_valid,
        input  in_funct3,
        input  in_rd,
        input  in_rs1,
        input  in_rs2,
        input  wb_ready,
        output in_ready,
        output wb_valid,
        output wb_rd,
        output wb_data,
        output wb_illegal
    );

endinterface

// File: rtl/fp_sgnj_dispatch_fifo.sv
// fp_op_fifo: small synchronous FIFO holding queued sign-injection ops.
// Push is ignored when full, pop is ignored when empty.
module fp_op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 72
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & (cnt != '0);
    assign dout    = mem[rp];
    assign count   = cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/fp_sgnj_dispatch.sv
// fp_sgnj_dispatch: issue/writeback stage for the FSGNJ/FSGNJN/FSGNJX units.
// Queues ops, drives the shared operand bus, returns {rd, data} to the FP RF.
module fp_sgnj_dispatch
    import fp_sgnj_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    fp_sgnj_if.slave    bus,
    output logic [31:0] op_rs1,
    output logic [31:0] op_rs2,
    output logic        en_sgnj,
    output logic        en_sgnjn,
    output logic        en_sgnjx,
    input  logic [31:0] res_sgnj,
    input  logic [31:0] res_sgnjn,
    input  logic [31:0] res_sgnjx,
    output logic [AW:0] fifo_count
);

    state_t      st;
    state_t      nxt;
    op_t         in_op;
    op_t         head;
    logic        full;
    logic [AW:0] cnt;
    logic        pop;
    logic        cap;
    logic        wb_done;
    sel_t        dec;
    sel_t        en_q;
    sel_t        op_sel;
    logic        op_ill;
    logic [4:0]  op_rd;
    logic [31:0] res_mux;

    assign in_op = {bus.in_funct3, bus.in_rd, bus.in_rs1, bus.in_rs2};

    fp_op_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(op_t))
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (bus.in_valid),
        .pop   (pop),
        .din   (in_op),
        .dout  (head),
        .full  (full),
        .count (cnt)
    );

    assign bus.in_ready = ~full;
    assign fifo_count   = cnt;
    assign dec          = f3_decode(head.funct3);
    assign en_sgnj      = en_q[0];
    assign en_sgnjn     = en_q[1];
    assign en_sgnjx     = en_q[2];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) st <= IDLE;
        else      st <= nxt;
    end

    // WB hands straight to ISSUE when work is queued, giving 3 cycles/op
    always_comb begin
        nxt     = st;
        pop     = 1'b0;
        cap     = 1'b0;
        wb_done = 1'b0;
        unique case (st)
            IDLE: begin
                if (cnt != '0) begin
                    pop = 1'b1;
                    nxt = ISSUE;
                end
            end
            ISSUE: begin
                nxt = CAPTURE;
            end
            CAPTURE: begin
                cap = 1'b1;
                nxt = WB;
            end
            WB: begin
                if (bus.wb_ready) begin
                    wb_done = 1'b1;
                    if (cnt != '0) begin
                        pop = 1'b1;
                        nxt = ISSUE;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        res_mux = '0;
        unique case (1'b1)
            op_sel[0]: res_mux = res_sgnj;
            op_sel[1]: res_mux = res_sgnjn;
            op_sel[2]: res_mux = res_sgnjx;
            default:   res_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_rs1         <= '0;
            op_rs2         <= '0;
            op_rd          <= '0;
            op_sel         <= '0;
            op_ill         <= 1'b0;
            en_q           <= '0;
            bus.wb_valid   <= 1'b0;
            bus.wb_rd      <= '0;
            bus.wb_data    <= '0;
            bus.wb_illegal <= 1'b0;
        end else begin
            en_q <= '0;
            if (pop) begin
                op_rs1 <= head.rs1;
                op_rs2 <= head.rs2;
                op_rd  <= head.rd;
                op_sel <= dec;
                op_ill <= (dec == '0);
                en_q   <= dec;
            end
            if (cap) begin
                bus.wb_valid   <= 1'b1;
                bus.wb_data    <= res_mux;
                bus.wb_rd      <= op_rd;
                bus.wb_illegal <= op_ill;
            end else if (wb_done) begin
                bus.wb_valid <= 1'b0;
            end
        end
    end

endmodule
